// File: rtl/data_memory_byte.sv
// -----------------------------------------------------------------------------
// data_memory_byte
//
// Byte-addressable, little-endian data memory built from 32-bit words with
// four byte lanes. It supports byte, halfword and word loads and stores.
// Loads can be sign- or zero-extended. Misaligned or reserved-size requests
// are rejected with an o_err pulse.
//
// After reset, a CLEAR phase zeroes every word, one word per cycle. Requests
// are accepted only in IDLE. The memory array itself has no reset.
//
// Parameters
//   RAM_DEPTH  depth in 32-bit words (power of two, >= 4)
//   NB_DATA    data width, fixed at 32
//   NB_ADDR    byte-address width, log2(RAM_DEPTH)+2
//
// Ports
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_valid    request strobe
//   i_we       1 = store, 0 = load
//   i_size     00 byte, 01 halfword, 10 word, 11 reserved
//   i_signed   sign-extend loads when 1
//   i_addr     byte address
//   i_data     store data, right-aligned
//   o_ready    high in IDLE (requests accepted)
//   o_data     load result, right-aligned and extended; holds while o_valid=0
//   o_valid    one-cycle pulse per completed load
//   o_err      one-cycle pulse per rejected request
//
// Configuration
//   DATA_MEM_OUTREG_EN  when defined, an extra output register stage is added.
//                       Load and error latency become 2 cycles instead of 1.
// -----------------------------------------------------------------------------
module data_memory_byte #(
    parameter int unsigned RAM_DEPTH = 1024,
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned NB_ADDR   = 12
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic               i_we,
    input  logic [1:0]         i_size,
    input  logic               i_signed,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_err
);

    localparam int unsigned NB_IDX = NB_ADDR - 2;
    localparam logic [NB_IDX-1:0] LastIdx = NB_IDX'(RAM_DEPTH - 1);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [NB_IDX-1:0] cnt_q, cnt_d;

    // ---------------------------------------------------------------------
    // Control FSM: CLEAR walks the word counter across the whole array
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + NB_IDX'(1);
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready = (state_q == StIdle);

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic              accept;
    logic              bad_req;
    logic              st_en;
    logic              ld_en;
    logic              err_en;
    logic [NB_IDX-1:0] idx;
    logic [1:0]        lane;

    assign accept = i_valid & o_ready;
    assign idx    = i_addr[NB_ADDR-1:2];
    assign lane   = i_addr[1:0];

    always_comb begin
        bad_req = 1'b0;
        unique case (i_size)
            SizeByte: bad_req = 1'b0;
            SizeHalf: bad_req = lane[0];
            SizeWord: bad_req = (lane != 2'b00);
            default:  bad_req = 1'b1;
        endcase
    end

    assign st_en  = accept & ~bad_req & i_we;
    assign ld_en  = accept & ~bad_req & ~i_we;
    assign err_en = accept & bad_req;

    // Store data is replicated across lanes so each lane slice is a fixed
    // bit range; the byte enables pick which lanes actually get written.
    logic [3:0]         wr_be;
    logic [NB_DATA-1:0] wr_data;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = i_data;
        unique case (i_size)
            SizeByte: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{i_data[7:0]}};
            end
            SizeHalf: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_data[15:0]}};
            end
            SizeWord: begin
                wr_be   = 4'b1111;
                wr_data = i_data;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = i_data;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Storage: no reset port, zeroing happens only via CLEAR
    // ---------------------------------------------------------------------
    logic [NB_DATA-1:0] mem [RAM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else if (st_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) begin
                    mem[idx][l*8 +: 8] <= wr_data[l*8 +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load path: asynchronous read, lane select and extension, then register
    // ---------------------------------------------------------------------
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] ld_data;

    assign rd_word = mem[idx];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte = rd_word[7:0];
        unique case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        ld_data = rd_word;
        unique case (i_size)
            SizeByte: ld_data = {{24{i_signed & rd_byte[7]}}, rd_byte};
            SizeHalf: ld_data = {{16{i_signed & rd_half[15]}}, rd_half};
            default:  ld_data = rd_word;
        endcase
    end

    // First result stage. Data only moves on a good load, so it holds across
    // stores, errors and idle cycles.
    logic               s1_valid_q;
    logic               s1_err_q;
    logic [NB_DATA-1:0] s1_data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= ld_en;
            s1_err_q   <= err_en;
            if (ld_en) begin
                s1_data_q <= ld_data;
            end
        end
    end

`ifdef DATA_MEM_OUTREG_EN
    logic               s2_valid_q;
    logic               s2_err_q;
    logic [NB_DATA-1:0] s2_data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_err_q   <= s1_err_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

    assign o_valid = s2_valid_q;
    assign o_err   = s2_err_q;
    assign o_data  = s2_data_q;
`else
    assign o_valid = s1_valid_q;
    assign o_err   = s1_err_q;
    assign o_data  = s1_data_q;
`endif

endmodule

// File: tb/tb_data_memory_byte.sv
// -----------------------------------------------------------------------------
// tb_data_memory_byte
//
// Directed bench for data_memory_byte. It covers CLEAR timing, accesses in
// every lane and size, sign and zero extension, rejected requests, last-word
// access, and a short reset in the middle of a load stream.
//
// Each accepted load or rejected request pushes its expected outcome, with
// the cycle it is due, onto a scoreboard queue. Every cycle the outputs are
// compared with the queue head, or with "no pulse, data held" when nothing is
// due.
// -----------------------------------------------------------------------------
module tb_data_memory_byte;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned NB_ADDR = 12;
`ifdef DATA_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int KStore = 0;
    localparam int KLoad  = 1;
    localparam int KErr   = 2;

    localparam logic [1:0] SzB = 2'b00;
    localparam logic [1:0] SzH = 2'b01;
    localparam logic [1:0] SzW = 2'b10;
    localparam logic [1:0] SzR = 2'b11;

    logic               i_clk = 1'b0;
    logic               i_reset_n;
    logic               i_valid;
    logic               i_we;
    logic [1:0]         i_size;
    logic               i_signed;
    logic [NB_ADDR-1:0] i_addr;
    logic [31:0]        i_data;
    logic               o_ready;
    logic [31:0]        o_data;
    logic               o_valid;
    logic               o_err;

    data_memory_byte #(
        .RAM_DEPTH (DEPTH),
        .NB_DATA   (32),
        .NB_ADDR   (NB_ADDR)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_we      (i_we),
        .i_size    (i_size),
        .i_signed  (i_signed),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          clr_edges = 0;
    logic [31:0] exp_odata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare outputs against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        cyc++;
        clr_edges++;
        #1;
        chk("ready", 32'(o_ready), 32'(clr_edges >= int'(DEPTH)));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("valid", 32'(o_valid), 32'(!e.is_err));
            chk("err", 32'(o_err), 32'(e.is_err));
            if (!e.is_err) begin
                exp_odata = e.data;
            end
            chk("data", o_data, exp_odata);
        end else begin
            chk("idle_valid", 32'(o_valid), 32'd0);
            chk("idle_err", 32'(o_err), 32'd0);
            chk("hold_data", o_data, exp_odata);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [NB_ADDR-1:0] addr, input logic [31:0] data);
        i_valid  = 1'b1;
        i_we     = we;
        i_size   = size;
        i_signed = sgn;
        i_addr   = addr;
        i_data   = data;
    endtask

    task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [NB_ADDR-1:0] addr, input logic [31:0] data,
                       input int kind, input logic [31:0] exp);
        exp_t e;
        drive(we, size, sgn, addr, data);
        // Only requests made while the model says IDLE are accepted.
        if (kind != KStore && clr_edges >= int'(DEPTH)) begin
            e.due    = cyc + LAT;
            e.is_err = (kind == KErr);
            e.data   = exp;
            sb.push_back(e);
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic ld(input logic [1:0] size, input logic sgn,
                      input logic [NB_ADDR-1:0] addr, input logic [31:0] exp);
        req(1'b0, size, sgn, addr, 32'h0, KLoad, exp);
    endtask

    task automatic st(input logic [1:0] size, input logic [NB_ADDR-1:0] addr,
                      input logic [31:0] data);
        req(1'b1, size, 1'b0, addr, data, KStore, 32'h0);
    endtask

    task automatic bad(input logic we, input logic [1:0] size, input logic [NB_ADDR-1:0] addr);
        req(we, size, 1'b0, addr, 32'hFFFF_FFFF, KErr, 32'h0);
    endtask

    task automatic idle();
        i_valid = 1'b0;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
        chk({tag, "_data"}, o_data, 32'd0);
    endtask

    // Sub-cycle reset pulse between two rising edges.
    task automatic short_reset();
        #2 i_reset_n = 1'b0;
        #1 check_reset_values("rst_pulse");
        #3 i_reset_n = 1'b1;
        sb.delete();
        exp_odata = 32'h0;
        clr_edges = 0;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_we      = 1'b0;
        i_size    = SzW;
        i_signed  = 1'b0;
        i_addr    = '0;
        i_data    = '0;
        exp_odata = 32'h0;

        #2 check_reset_values("rst_t2");
        #10 check_reset_values("rst_t12");
        i_reset_n = 1'b1;
        clr_edges = 0;

        // CLEAR: requests here must be ignored; ready rises after exactly DEPTH edges.
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == 9)       st(SzW, 12'h010, 32'hDEAD_BEEF);
            else if (i == 20) ld(SzW, 1'b0, 12'h010, 32'h0);
            else              idle();
        end

        ld(SzW, 1'b0, 12'h010, 32'h0000_0000);
        idle();

        st(SzW, 12'h004, 32'h1122_3344);
        ld(SzB, 1'b1, 12'h007, 32'h0000_0011);
        ld(SzB, 1'b0, 12'h004, 32'h0000_0044);
        ld(SzH, 1'b1, 12'h006, 32'h0000_1122);
        ld(SzH, 1'b0, 12'h004, 32'h0000_3344);
        ld(SzB, 1'b0, 12'h005, 32'h0000_0033);
        ld(SzB, 1'b1, 12'h006, 32'h0000_0022);
        ld(SzW, 1'b1, 12'h004, 32'h1122_3344);
        idle();
        idle();

        st(SzW, 12'h008, 32'h0000_0000);
        st(SzB, 12'h009, 32'h1234_5680);
        ld(SzB, 1'b1, 12'h009, 32'hFFFF_FF80);
        ld(SzB, 1'b0, 12'h009, 32'h0000_0080);
        ld(SzW, 1'b0, 12'h008, 32'h0000_8000);

        st(SzH, 12'h00E, 32'hAAAA_BEEF);
        ld(SzH, 1'b1, 12'h00E, 32'hFFFF_BEEF);
        ld(SzH, 1'b0, 12'h00E, 32'h0000_BEEF);
        ld(SzW, 1'b1, 12'h00C, 32'hBEEF_0000);
        idle();

        // Rejected requests: o_err only, data held, memory untouched.
        bad(1'b0, SzW, 12'h002);
        idle();
        bad(1'b1, SzH, 12'h001);
        ld(SzW, 1'b0, 12'h000, 32'h0000_0000);
        bad(1'b0, SzR, 12'h000);
        bad(1'b1, SzW, 12'h00D);
        bad(1'b0, SzH, 12'h003);
        ld(SzW, 1'b0, 12'h00C, 32'hBEEF_0000);

        st(SzW, 12'hFFC, 32'hCAFE_F00D);
        ld(SzW, 1'b0, 12'hFFC, 32'hCAFE_F00D);
        ld(SzB, 1'b1, 12'hFFF, 32'hFFFF_FFCA);
        idle();

        // Reset mid-stream: in-flight loads vanish, CLEAR reruns.
        st(SzW, 12'h010, 32'h55AA_55AA);
        ld(SzW, 1'b0, 12'h010, 32'h55AA_55AA);
        ld(SzW, 1'b0, 12'h010, 32'h55AA_55AA);
        ld(SzW, 1'b0, 12'h010, 32'h55AA_55AA);
        drive(1'b0, SzW, 1'b0, 12'h010, 32'h0);
        short_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i < 50) ld(SzW, 1'b0, 12'h010, 32'h0);
            else        idle();
        end
        ld(SzW, 1'b0, 12'h010, 32'h0000_0000);
        ld(SzW, 1'b0, 12'h004, 32'h0000_0000);
        ld(SzW, 1'b0, 12'hFFC, 32'h0000_0000);
        ld(SzH, 1'b0, 12'h00E, 32'h0000_0000);

        for (int i = 0; i < LAT + 2; i++) idle();
        chk("drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
